// File: rtl/i2s_ser.sv
// i2s_ser: Philips I2S transmitter.
//
// Accepts 64-bit stereo samples ([63:32] left, [31:0] right, MSB-justified)
// over a valid/ready handshake, buffers one sample, and shifts each frame out
// as BCK/LRCK/DATA with the MSB one BCK after every LRCK edge. Each channel
// occupies a 32-bit slot. Samples are truncated to 16/24/32 bits when they
// are loaded.
//
// Optional feature: define I2S_SER_MUTE_EN to add the `mute` input. When mute
// is high at a frame load, a zero frame is sent. Any held sample is still
// consumed, so upstream is not stalled.
//
// Parameters:
//   BCK_DIV      BCK half-period in clk cycles (>= 2)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   in_data      stereo sample, [63:32] left, [31:0] right
//   in_valid     in_data valid
//   in_ready     holding register empty (registered)
//   bitnum       0=16, 1=24, 2/3=32 bit; sampled at frame load
//   mute         (I2S_SER_MUTE_EN only) send a zero frame; sampled at frame load
//   bck          bit clock
//   lrck         0=left, 1=right
//   data         serial data, changes on bck falling edge
//   underrun     1-clk pulse: frame loaded with no sample held
//   frame_start  1-clk pulse on the frame load cycle
module i2s_ser #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  bitnum,
`ifdef I2S_SER_MUTE_EN
  input  logic        mute,
`endif
  output logic        bck,
  output logic        lrck,
  output logic        data,
  output logic        underrun,
  output logic        frame_start
);

  localparam int unsigned DivW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bck_q, bck_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic            lrck_q, lrck_d;
  logic            data_q, data_d;
  logic [63:0]     shreg_q, shreg_d;
  logic [63:0]     hold_q, hold_d;
  logic            full_q, full_d;
  logic            in_ready_q, in_ready_d;
  logic            underrun_q, underrun_d;
  logic            frame_start_q, frame_start_d;

  logic            div_end;
  logic            fall;
  logic            load;
  logic            accept;
  logic            mute_sel;
  logic [31:0]     chan_mask;
  logic [63:0]     frame;

`ifdef I2S_SER_MUTE_EN
  assign mute_sel = mute;
`else
  assign mute_sel = 1'b0;
`endif

  always_comb begin
    div_end = (div_cnt_q == DivW'(BCK_DIV - 1));
    fall    = div_end && bck_q;
    // The fall event where bit_cnt goes 0 -> 1 starts a new frame.
    load    = fall && (bit_cnt_q == 6'd0);
    accept  = in_valid && in_ready_q;

    unique case (bitnum)
      2'd0:    chan_mask = 32'hFFFF_0000;
      2'd1:    chan_mask = 32'hFFFF_FF00;
      default: chan_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    div_cnt_d     = div_end ? '0 : div_cnt_q + DivW'(1);
    bck_d         = bck_q ^ div_end;
    bit_cnt_d     = bit_cnt_q;
    lrck_d        = lrck_q;
    data_d        = data_q;
    shreg_d       = shreg_q;
    hold_d        = hold_q;
    full_d        = full_q;
    underrun_d    = 1'b0;
    frame_start_d = 1'b0;
    frame         = '0;

    if (fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrck_d    = bit_cnt_d[5];
      if (load) begin
        frame_start_d = 1'b1;
        if (mute_sel) begin
          full_d = 1'b0;
        end else if (full_q) begin
          frame  = hold_q & {chan_mask, chan_mask};
          full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
        end
        data_d  = frame[63];
        shreg_d = {frame[62:0], 1'b0};
      end else begin
        data_d  = shreg_q[63];
        shreg_d = {shreg_q[62:0], 1'b0};
      end
    end

    // in_ready_q=1 implies full_q=0, so an accept never collides with a load
    // that consumes the holding register.
    if (accept) begin
      hold_d = in_data;
      full_d = 1'b1;
    end

    // Drops right after an accept; rises one cycle after the load that empties it.
    in_ready_d = !full_q && !full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      bck_q         <= 1'b0;
      bit_cnt_q     <= '0;
      lrck_q        <= 1'b0;
      data_q        <= 1'b0;
      shreg_q       <= '0;
      hold_q        <= '0;
      full_q        <= 1'b0;
      in_ready_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bck_q         <= bck_d;
      bit_cnt_q     <= bit_cnt_d;
      lrck_q        <= lrck_d;
      data_q        <= data_d;
      shreg_q       <= shreg_d;
      hold_q        <= hold_d;
      full_q        <= full_d;
      in_ready_q    <= in_ready_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bck         = bck_q;
  assign lrck        = lrck_q;
  assign data        = data_q;
  assign in_ready    = in_ready_q;
  assign underrun    = underrun_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/i2s_ser.md
Name: i2s_ser

Overview:
- I2S transmitter: the opposite end of the I2S deserializer.
- Takes 64-bit parallel stereo samples through a valid/ready handshake and serializes them into standard Philips I2S.
- Outputs are BCK, LRCK and DATA, with a 1-bit MSB delay after each LRCK edge, driving the DAC serial port (i2s_dac_*).
- BCK is derived from clk by an integer divider. One sample is buffered so upstream has a full frame to supply the next.

Parameters:
- BCK_DIV, 4, BCK half-period in clk cycles (>=2); BCK period = 2*BCK_DIV clk.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  64  [63:32] left, [31:0] right, MSB-justified
- in_valid  input  1  in_data valid
- in_ready  output  1  holding register empty; transfer on in_valid&&in_ready
- bitnum  input  2  0=16 bit, 1=24 bit, 2/3=32 bit; sampled at frame load
- bck  output  1  I2S bit clock
- lrck  output  1  0=left, 1=right
- data  output  1  serial data, changes on bck falling edge
- underrun  output  1  1-clk pulse: frame loaded with no sample available
- frame_start  output  1  1-clk pulse on the frame load cycle

Behaviour:
- Reset values (while reset=1 and the cycle after): bck=0, lrck=0, data=0, underrun=0, frame_start=0, in_ready=0. Internal: div_cnt=0, bit_cnt=0, full=0, shreg=0.
  - in_ready = !full && !reset, registered, so it is 1 the cycle after reset deasserts.
- Divider:
  - div_cnt counts 0..BCK_DIV-1; at BCK_DIV-1 it wraps to 0 and bck toggles.
  - A 1→0 toggle is a "fall event".
  - First rising edge of bck: BCK_DIV clk after reset release. First fall: 2*BCK_DIV clk after.
- At each fall event:
  - bit_cnt <= (bit_cnt+1) mod 64.
  - lrck <= (bit_cnt_next >= 32).
  - data <= shreg[63]; shreg <= {shreg[62:0],1'b0}. Loading is the exception below.
- Frame load, at the fall event where bit_cnt goes 0→1:
  - shreg is loaded with the new frame and data <= new left MSB. Left MSB is therefore driven during bit_cnt=1, one BCK after lrck falls.
  - Left bits occupy bit_cnt 1..32; right bits occupy 33..63 and bit_cnt 0 of the next frame (right LSB).
  - Slot width is always 32 bits per channel regardless of bitnum.
- Bitnum masking at load: the low 32-N bits of each channel word are forced to 0 (N=16/24/32).
- Holding register:
  - Accepting a transfer sets full and stores in_data.
  - Frame load with full=1: shreg takes the holding register, full clears, and frame_start pulses. in_ready returns to 1 on the next cycle.
  - Frame load with full=0: shreg is loaded with zeros, underrun pulses for 1 clk, and frame_start still pulses.
- Simultaneity: a transfer cannot coincide with a load that consumes the holding register, since in_ready=0 while full.
  - A transfer in the same cycle as an underrun load is accepted. It is used at the next frame, and that frame is not retroactively filled.
- First frame after reset: its load (first 0→1 event) normally underruns unless a sample was accepted in the preceding 2*BCK_DIV clk.
- Reset mid-frame: aborts immediately, outputs return to reset values, and any held sample is discarded.
- in_data must be held stable while in_valid=1 && in_ready=0.

Optional Feature:
- Macro I2S_SER_MUTE_EN.
- Defined: adds input port mute (1 bit), sampled at frame load.
  - mute=1 at load: shreg is loaded with zeros and the holding register is still consumed if full (upstream is not stalled). underrun is not asserted; frame_start still pulses.
  - Mute takes effect on frame boundaries only.
- Undefined: no mute port; behaviour exactly as above.

Test Plan:
- Reset, BCK_DIV=4, no input:
  - bck period is 8 clk; first rising edge 4 clk after reset release.
  - lrck is 0 for 32 BCK and 1 for 32 BCK (512 clk frame).
  - data stays 0; underrun pulses once per frame.
- bitnum=2, in_data=64'hA5A5_0001_8000_00FF written before the first load:
  - Left bits appear MSB-first on bit_cnt 1..32, first bit 1.
  - Right word 32'h8000_00FF appears on bit_cnt 33..63 and 0; right LSB=1 is driven at bit_cnt 0 of the next frame.
  - No underrun on that frame.
- bitnum=0, in_data=64'hFFFF_FFFF_FFFF_FFFF: serial stream shows 16 ones then 16 zeros per channel slot.
- Back-to-back:
  - Hold in_valid=1 with a counting pattern; in_ready drops after each accept and rises one clk after each frame_start.
  - Exactly one sample is consumed per frame; no underrun after the first loaded frame.
  - A fixed in_data value is not valid here: once in_ready rises it is accepted immediately, so there is no gap to model.
- Assert reset mid-frame (bit_cnt=20) with full=1:
  - Next cycle bck=lrck=data=0 and in_ready=0; then in_ready=1.
  - Previously held sample is never transmitted.
- I2S_SER_MUTE_EN defined:
  - Assert mute with sample 64'h1234_5678_9ABC_DEF0 held → zero frame transmitted, in_ready returns to 1, no underrun.
  - Deassert mute → next sample is transmitted.
